// File: rtl/merge_pkg.sv
// Shared types and constants for the fill request scheduler slice.
// Sizing is set here so the interface, the picker and the top agree.
package merge_pkg;

   localparam int NUM_UNITS       = 4;
   localparam int ADDR_W          = 6;
   localparam int MAX_OUTSTANDING = 2;
   localparam int UNIT_W          = $clog2(NUM_UNITS);
   localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2
   } sched_state_t;

   // Turns a unit index into a one-hot vector across all units.
   function automatic logic [NUM_UNITS-1:0] unitOneHot(input logic [UNIT_W-1:0] idx);
      logic [NUM_UNITS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Advances a round-robin pointer by one, wrapping at the last unit.
   function automatic logic [UNIT_W-1:0] nextUnit(input logic [UNIT_W-1:0] idx);
      logic [UNIT_W-1:0] n;
      if (idx == UNIT_W'(NUM_UNITS - 1)) begin
         n = '0;
      end else begin
         n = idx + UNIT_W'(1);
      end
      return n;
   endfunction

endpackage

// File: rtl/fill_req_scheduler_if.sv
// Bundle of the merge-unit request side and the page-buffer fill side.
// The master modport is the environment (units + page buffer); the slave
// modport is the scheduler itself.
interface fill_req_scheduler_if;
   import merge_pkg::*;

   logic [NUM_UNITS-1:0]             req_valid;
   logic [NUM_UNITS-1:0][ADDR_W-1:0] req_addr;
   logic [NUM_UNITS-1:0]             req_urgent;
   logic [NUM_UNITS-1:0]             req_accepted;
   logic                             accept_ready;
   logic                             fill_done;
   logic                             send_fill_req;
   logic [ADDR_W-1:0]                fill_addr;
   logic [UNIT_W-1:0]                fill_unit;

   modport master (
      output req_valid,
      output req_addr,
      output req_urgent,
      output accept_ready,
      output fill_done,
      input  req_accepted,
      input  send_fill_req,
      input  fill_addr,
      input  fill_unit
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      input  req_urgent,
      input  accept_ready,
      input  fill_done,
      output req_accepted,
      output send_fill_req,
      output fill_addr,
      output fill_unit
   );

endinterface

// File: rtl/rr_prio_picker.sv
// Combinational winner picker: scans the candidate vector starting at the
// round-robin pointer (mode 0) or at unit 0 (mode 1) and reports the first
// candidate found.
module rr_prio_picker
   import merge_pkg::*;
(
   input  logic [NUM_UNITS-1:0] i_cand,
   input  logic [UNIT_W-1:0]    i_rrPtr,
   input  logic                 i_mode,
   output logic [UNIT_W-1:0]    o_winner,
   output logic                 o_found
);

   logic [UNIT_W-1:0] w_idx;

   // Walk the units in priority order and keep the first one that is a candidate.
   always_comb begin
      o_winner = '0;
      o_found  = 1'b0;
      w_idx    = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (i_mode) begin
            w_idx = UNIT_W'(i);
         end else begin
            w_idx = UNIT_W'((int'(i_rrPtr) + i) % NUM_UNITS);
         end
         if (!o_found && i_cand[w_idx]) begin
            o_found  = 1'b1;
            o_winner = w_idx;
         end
      end
   end

endmodule

// File: rtl/fill_req_scheduler.sv
// Shares one page-buffer fill port among the merge units of a slow block.
// Urgent (bin-empty) requests win first; otherwise round-robin or fixed
// priority picks the winner. Issue is limited by a credit count of fills
// in flight, and every issue is followed by a one-cycle gap so the granted
// unit can drop its request before the next arbitration.
module fill_req_scheduler
   import merge_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_unit_en,
   input  logic                 i_mode,
   fill_req_scheduler_if.slave  bus,
   output logic [CNT_W-1:0]     o_outstanding,
   output logic                 o_busy,
   output logic                 o_err_underflow
);

   sched_state_t          r_state;
   logic [UNIT_W-1:0]     r_rrPtr;
   logic [NUM_UNITS-1:0]  r_maskLast;
   logic [NUM_UNITS-1:0]  r_reqAccepted;
   logic                  r_sendFillReq;
   logic [ADDR_W-1:0]     r_fillAddr;
   logic [UNIT_W-1:0]     r_fillUnit;
   logic [CNT_W-1:0]      r_outstanding;
   logic                  r_errUnderflow;

   logic [NUM_UNITS-1:0]  w_eligible;
   logic [NUM_UNITS-1:0]  w_urgentCand;
   logic [NUM_UNITS-1:0]  w_cand;
   logic [UNIT_W-1:0]     w_winner;
   logic                  w_found;
   logic                  w_creditOk;
   logic                  w_launch;
   logic                  w_issueInc;
   logic [CNT_W-1:0]      w_cntNext;
   logic                  w_underflow;

   assign w_eligible   = bus.req_valid & ~r_maskLast;
   assign w_urgentCand = w_eligible & bus.req_urgent;
   assign w_cand       = (|w_urgentCand) ? w_urgentCand : w_eligible;
   assign w_creditOk   = (r_outstanding < CNT_W'(MAX_OUTSTANDING));
   assign w_launch     = (r_state == IDLE) && i_unit_en && bus.accept_ready
                         && w_creditOk && w_found;
   assign w_issueInc   = (r_state == ISSUE);

   rr_prio_picker u_picker (
      .i_cand   (w_cand),
      .i_rrPtr  (r_rrPtr),
      .i_mode   (i_mode),
      .o_winner (w_winner),
      .o_found  (w_found)
   );

   // Next credit count: an issue and a completion in the same cycle cancel out,
   // and a completion with nothing in flight is flagged instead of wrapping.
   always_comb begin
      w_cntNext   = r_outstanding;
      w_underflow = 1'b0;
      if (w_issueInc && !bus.fill_done) begin
         w_cntNext = r_outstanding + CNT_W'(1);
      end else if (!w_issueInc && bus.fill_done) begin
         if (r_outstanding == '0) begin
            w_underflow = 1'b1;
         end else begin
            w_cntNext = r_outstanding - CNT_W'(1);
         end
      end
   end

   // Credit counter and sticky underflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_outstanding  <= '0;
         r_errUnderflow <= 1'b0;
      end else begin
         r_outstanding <= w_cntNext;
         if (w_underflow) begin
            r_errUnderflow <= 1'b1;
         end
      end
   end

   // Scheduler FSM: IDLE arbitrates and latches the winner, ISSUE drives the
   // one-cycle pulses, GAP masks the last winner while it drops its request.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_rrPtr       <= '0;
         r_maskLast    <= '0;
         r_reqAccepted <= '0;
         r_sendFillReq <= 1'b0;
         r_fillAddr    <= '0;
         r_fillUnit    <= '0;
      end else begin
         r_reqAccepted <= '0;
         r_sendFillReq <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_launch) begin
                  r_state       <= ISSUE;
                  r_fillUnit    <= w_winner;
                  r_fillAddr    <= bus.req_addr[w_winner];
                  r_sendFillReq <= 1'b1;
                  r_reqAccepted <= unitOneHot(w_winner);
               end
            end
            ISSUE: begin
               r_state    <= GAP;
               r_maskLast <= unitOneHot(r_fillUnit);
               if (!i_mode) begin
                  r_rrPtr <= nextUnit(r_fillUnit);
               end
            end
            GAP: begin
               r_state    <= IDLE;
               r_maskLast <= '0;
            end
            default: begin
               r_state    <= IDLE;
               r_maskLast <= '0;
            end
         endcase
      end
   end

   assign bus.req_accepted  = r_reqAccepted;
   assign bus.send_fill_req = r_sendFillReq;
   assign bus.fill_addr     = r_fillAddr;
   assign bus.fill_unit     = r_fillUnit;

   assign o_outstanding   = r_outstanding;
   assign o_err_underflow = r_errUnderflow;
   assign o_busy          = (r_state != IDLE) || (r_outstanding != '0);

endmodule

// File: tb/tb_fill_req_scheduler.sv
// Directed bench for the fill request scheduler: single issue, round-robin
// order, urgent preemption, credit stall, fixed priority with enable, and
// underflow / mid-issue reset. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_fill_req_scheduler;
   import merge_pkg::*;

   logic              clk;
   logic              rst;
   logic              unitEn;
   logic              mode;
   logic [CNT_W-1:0]  outstanding;
   logic              busy;
   logic              errUnderflow;

   int checkCount = 0;
   int passCount  = 0;
   int cycleCount = 0;

   logic [ADDR_W-1:0] addrTab [NUM_UNITS] = '{6'h0A, 6'h21, 6'h15, 6'h3F};

   fill_req_scheduler_if bus();

   fill_req_scheduler dut (
      .clk             (clk),
      .rst             (rst),
      .i_unit_en       (unitEn),
      .i_mode          (mode),
      .bus             (bus),
      .o_outstanding   (outstanding),
      .o_busy          (busy),
      .o_err_underflow (errUnderflow)
   );

   // Free-running clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to measure issue latency and spacing.
   always @(posedge clk) begin
      cycleCount <= cycleCount + 1;
   end

   // Hard stop in case something upstream hangs.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [NUM_UNITS-1:0] valid,
                                input logic [NUM_UNITS-1:0] urgent,
                                input logic m, input logic en);
      bus.req_valid    = valid;
      bus.req_urgent   = urgent;
      mode             = m;
      unitEn           = en;
      bus.accept_ready = 1'b1;
   endtask

   task automatic doReset();
      rst              = 1'b1;
      bus.req_valid    = '0;
      bus.req_urgent   = '0;
      bus.fill_done    = 1'b0;
      bus.accept_ready = 1'b0;
      unitEn           = 1'b0;
      mode             = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pulseDone();
      bus.fill_done = 1'b1;
      @(negedge clk);
      bus.fill_done = 1'b0;
   endtask

   // Waits (bounded) for an issue pulse, captures it, optionally returns the
   // fill in the same cycle, then steps past the gap cycle.
   task automatic waitIssue(input int budget, input bit doDone,
                            output logic [UNIT_W-1:0] unit,
                            output logic [ADDR_W-1:0] addr,
                            output logic [NUM_UNITS-1:0] accepted,
                            output logic [CNT_W-1:0] cntAtIssue,
                            output int when);
      bit seen;
      seen       = 1'b0;
      unit       = '0;
      addr       = '0;
      accepted   = '0;
      cntAtIssue = '0;
      when       = -1;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (bus.send_fill_req === 1'b1) begin
            seen       = 1'b1;
            unit       = bus.fill_unit;
            addr       = bus.fill_addr;
            accepted   = bus.req_accepted;
            cntAtIssue = outstanding;
            when       = cycleCount;
         end
      end
      if (!seen) begin
         checkOutput("issueTimeout", 32'd0, 32'd1);
      end else begin
         if (doDone) bus.fill_done = 1'b1;
         @(negedge clk);
         bus.fill_done = 1'b0;
      end
   endtask

   task automatic countSends(input int cycles, output int sends);
      sends = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (bus.send_fill_req === 1'b1) sends++;
      end
   endtask

   initial begin
      logic [UNIT_W-1:0]    unit;
      logic [ADDR_W-1:0]    addr;
      logic [NUM_UNITS-1:0] acc;
      logic [CNT_W-1:0]     cnt;
      int                   when;
      int                   prevWhen;
      int                   start;
      int                   sends;
      int                   rrOrder [5] = '{0, 1, 2, 3, 0};
      int                   urgOrder [4] = '{3, 0, 1, 2};
      bit                   seen;

      for (int i = 0; i < NUM_UNITS; i++) bus.req_addr[i] = addrTab[i];
      doReset();

      checkOutput("rstSend", bus.send_fill_req, 0);
      checkOutput("rstAccepted", bus.req_accepted, 0);
      checkOutput("rstFillAddr", bus.fill_addr, 0);
      checkOutput("rstFillUnit", bus.fill_unit, 0);
      checkOutput("rstOutstanding", outstanding, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstErr", errUnderflow, 0);

      $display("[TB] single request");
      applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b1);
      start = cycleCount;
      waitIssue(8, 1'b0, unit, addr, acc, cnt, when);
      checkOutput("singleLatency", when - start, 1);
      checkOutput("singleUnit", unit, 2);
      checkOutput("singleAddr", addr, 6'h15);
      checkOutput("singleAccepted", acc, 4'b0100);
      checkOutput("singleCntAtIssue", cnt, 0);
      checkOutput("singleGapSend", bus.send_fill_req, 0);
      checkOutput("singleGapAccepted", bus.req_accepted, 0);
      checkOutput("singleOutstanding", outstanding, 1);
      checkOutput("singleBusy", busy, 1);
      bus.req_valid = '0;
      pulseDone();
      checkOutput("singleDone", outstanding, 0);
      applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b1);
      waitIssue(8, 1'b1, unit, addr, acc, cnt, when);
      checkOutput("ptrAfterSingle", unit, 3);
      checkOutput("ptrAfterSingleAddr", addr, 6'h3F);
      checkOutput("coincideCount", outstanding, 0);

      $display("[TB] round-robin fairness");
      doReset();
      applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b1);
      prevWhen = 0;
      for (int k = 0; k < 5; k++) begin
         waitIssue(10, 1'b1, unit, addr, acc, cnt, when);
         checkOutput($sformatf("rrUnit%0d", k), unit, rrOrder[k]);
         checkOutput($sformatf("rrAddr%0d", k), addr, addrTab[rrOrder[k]]);
         checkOutput($sformatf("rrAccepted%0d", k), acc, 32'd1 << rrOrder[k]);
         if (k > 0) checkOutput($sformatf("rrSpacing%0d", k), when - prevWhen, 3);
         prevWhen = when;
      end
      checkOutput("rrOutstanding", outstanding, 0);

      $display("[TB] urgent preemption");
      doReset();
      applyStimulus(4'b1111, 4'b1000, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         waitIssue(10, 1'b1, unit, addr, acc, cnt, when);
         checkOutput($sformatf("urgUnit%0d", k), unit, urgOrder[k]);
         if (k == 0) applyStimulus(4'b0111, 4'b0000, 1'b0, 1'b1);
      end

      $display("[TB] credit limit");
      doReset();
      applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b1);
      waitIssue(10, 1'b0, unit, addr, acc, cnt, when);
      checkOutput("creditUnitA", unit, 0);
      waitIssue(10, 1'b0, unit, addr, acc, cnt, when);
      checkOutput("creditUnitB", unit, 1);
      countSends(12, sends);
      checkOutput("creditStallSends", sends, 0);
      checkOutput("creditStallCount", outstanding, 2);
      checkOutput("creditStallBusy", busy, 1);
      pulseDone();
      checkOutput("creditAfterDone", outstanding, 1);
      waitIssue(10, 1'b0, unit, addr, acc, cnt, when);
      checkOutput("creditUnitC", unit, 2);
      checkOutput("creditFinalCount", outstanding, 2);

      $display("[TB] fixed priority and enable");
      doReset();
      applyStimulus(4'b0110, 4'b0000, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         waitIssue(10, (k < 2), unit, addr, acc, cnt, when);
         checkOutput($sformatf("fixedUnit%0d", k), unit, 1);
      end
      unitEn = 1'b0;
      countSends(10, sends);
      checkOutput("enableBlockSends", sends, 0);
      checkOutput("enableBlockCount", outstanding, 1);
      pulseDone();
      checkOutput("enableDoneCount", outstanding, 0);
      checkOutput("enableNoErr", errUnderflow, 0);
      applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b1);
      waitIssue(10, 1'b1, unit, addr, acc, cnt, when);
      checkOutput("fixedKeepsPtr", unit, 0);
      bus.req_valid = '0;

      $display("[TB] underflow and reset during issue");
      repeat (3) @(negedge clk);
      pulseDone();
      checkOutput("underflowSet", errUnderflow, 1);
      checkOutput("underflowCount", outstanding, 0);
      repeat (3) @(negedge clk);
      checkOutput("underflowSticky", errUnderflow, 1);
      applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (bus.send_fill_req === 1'b1) begin
            seen = 1'b1;
            rst  = 1'b1;
         end
      end
      checkOutput("resetIssueSeen", seen, 1);
      @(negedge clk);
      checkOutput("midRstSend", bus.send_fill_req, 0);
      checkOutput("midRstAccepted", bus.req_accepted, 0);
      checkOutput("midRstFillAddr", bus.fill_addr, 0);
      checkOutput("midRstFillUnit", bus.fill_unit, 0);
      checkOutput("midRstOutstanding", outstanding, 0);
      checkOutput("midRstBusy", busy, 0);
      checkOutput("midRstErr", errUnderflow, 0);
      rst           = 1'b0;
      bus.req_valid = '0;
      @(negedge clk);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
